// File: rtl/div_signed_by_unsigned_seq.sv
// Sequential restoring divider: signed DW-bit dividend by unsigned BW-bit divisor.
// Produces one quotient bit per clock. The quotient is truncated toward zero and the
// remainder takes the sign of the dividend. Valid/ready handshake on both sides.
module div_signed_by_unsigned_seq #(
   parameter int unsigned DW = 7,
   parameter int unsigned BW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [BW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [BW:0]   remainder,
   output logic          div_zero
);

   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LastIter = CW'(DW - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e        state_q, state_d;
   logic          alive_q;              // low until the first edge after reset release
   logic          sign_q, sign_d;
   logic [DW-1:0] mag_q, mag_d;         // dividend magnitude; quotient bits shift in at the LSB
   logic [BW-1:0] div_q, div_d;
   logic [BW:0]   part_q, part_d;       // partial remainder
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [BW:0]   rem_q, rem_d;
   logic          dz_q, dz_d;
   logic          ov_q, ov_d;

   logic [BW:0]   shifted;
   logic          fits;
   logic [DW-1:0] dividend_abs;

   // The most negative dividend wraps to 2^(DW-1), which is its correct unsigned magnitude.
   assign dividend_abs = dividend[DW-1] ? -dividend : dividend;

   // Partial remainder is always below the divisor, so its top bit is zero before the shift.
   assign shifted = {part_q[BW-1:0], mag_q[DW-1]};
   assign fits    = (shifted >= {1'b0, div_q});

   assign in_ready  = (state_q == StIdle) && alive_q;
   assign out_valid = ov_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      div_d   = div_q;
      part_d  = part_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      ov_d    = ov_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid && alive_q) begin
               sign_d = dividend[DW-1];
               mag_d  = dividend_abs;
               div_d  = divisor;
               part_d = '0;
               cnt_d  = '0;
               if (divisor == '0) begin
                  // Result is known at once; out_valid follows one edge later in StDone.
                  state_d = StDone;
                  dz_d    = 1'b1;
                  quo_d   = '0;
                  rem_d   = '0;
               end else begin
                  state_d = StCalc;
               end
            end
         end

         StCalc: begin
            part_d = fits ? (shifted - {1'b0, div_q}) : shifted;
            mag_d  = {mag_q[DW-2:0], fits};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LastIter) begin
               state_d = StFix;
            end
         end

         StFix: begin
            // Negating zero yields zero, so a zero remainder stays zero.
            quo_d   = sign_q ? -mag_q : mag_q;
            rem_d   = sign_q ? -part_q : part_q;
            dz_d    = 1'b0;
            ov_d    = 1'b1;
            state_d = StDone;
         end

         StDone: begin
            if (!ov_q) begin
               ov_d = 1'b1;
            end else if (out_ready) begin
               ov_d    = 1'b0;
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         alive_q <= 1'b0;
         sign_q  <= 1'b0;
         mag_q   <= '0;
         div_q   <= '0;
         part_q  <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         div_q   <= div_d;
         part_q  <= part_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
      end
   end

endmodule
